// File: rtl/eth_mdio_pkg.sv
// Shared types and frame constants for the clause-22 MDIO master.
package eth_mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA,
    DONE
  } mdio_state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  // Header + TA + data as shifted out after the preamble. For reads the TA and
  // data positions are released on the pad, so they are filled with idle ones.
  function automatic logic [31:0] mdio_tx_word(input logic        wr,
                                               input logic [4:0]  phyad,
                                               input logic [4:0]  regad,
                                               input logic [15:0] wdata);
    if (wr) return {MDIO_ST, MDIO_OP_WR, phyad, regad, MDIO_TA_WR, wdata};
    else    return {MDIO_ST, MDIO_OP_RD, phyad, regad, 2'b11, 16'hFFFF};
  endfunction

endpackage

// File: rtl/eth_mdio_clkgen.sv
// MDC divider: CLK_DIV clocks per half-period, with single-cycle strobes marking
// the clock edge on which mdc goes 0->1 (rise_stb) and 1->0 (fall_stb).
// Held at count 0 with mdc low whenever disabled.
module eth_mdio_clkgen #(
  parameter int CLK_DIV = 10
) (
  input  logic msoc_clk,
  input  logic rstn,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = en && (cnt == CNT_LAST);
  assign rise_stb = wrap && !mdc;
  assign fall_stb = wrap && mdc;

  // Half-period counter; mdc toggles each time the count wraps.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO master: accepts one read/write request, serialises the frame
// on MDC/MDIO (IOBUF-style o/t pad controls) and returns read data.
//
// Handshake: a request is taken on a clock where req_valid && req_ready;
// req_ready is high only in IDLE. Completion is a one-cycle rsp_valid pulse
// with rsp_rdata/rsp_err, which hold until the next completion. The cycle
// after rsp_valid is IDLE again and can accept the next request.
module eth_mdio_master
  import eth_mdio_pkg::*;
#(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output mdio_state_t dbg_state
);

  localparam logic [5:0] PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;

  mdio_state_t state;
  logic [5:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [15:0] rx_sr;
  logic        is_wr;
  logic        ta_err;
  logic [31:0] tx_word;
  logic        clk_en;
  logic        fall_stb;
  logic        rise_stb;

  assign tx_word   = mdio_tx_word(req_write, req_phyad, req_regad, req_wdata);
  assign clk_en    = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);
  assign dbg_state = state;

  eth_mdio_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .en       (clk_en),
    .mdc      (mdc),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // Frame sequencer: a new bit is launched on each MDC falling strobe, read
  // bits are captured on each MDC rising strobe.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= 6'd0;
      tx_sr     <= 32'h0;
      rx_sr     <= 16'h0;
      is_wr     <= 1'b0;
      ta_err    <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;

      // Second TA bit must be pulled low by the PHY; data arrives MSB first.
      if (rise_stb && !is_wr) begin
        if ((state == TA) && (bit_cnt == 6'd0)) ta_err <= mdio_i;
        if (state == DATA) rx_sr <= {rx_sr[14:0], mdio_i};
      end

      unique case (state)
        IDLE: begin
          if (req_valid) begin
            is_wr     <= req_write;
            ta_err    <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            mdio_t    <= 1'b0;
            if (PREAMBLE_LEN == 0) begin
              state   <= HDR;
              bit_cnt <= 6'd13;
              mdio_o  <= tx_word[31];
              tx_sr   <= {tx_word[30:0], 1'b0};
            end else begin
              state   <= PRE;
              bit_cnt <= PRE_LAST;
              mdio_o  <= 1'b1;
              tx_sr   <= tx_word;
            end
          end
        end
        PRE: begin
          if (fall_stb) begin
            if (bit_cnt == 6'd0) begin
              state   <= HDR;
              bit_cnt <= 6'd13;
              mdio_o  <= tx_sr[31];
              tx_sr   <= {tx_sr[30:0], 1'b0};
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
        end
        HDR: begin
          if (fall_stb) begin
            mdio_o <= tx_sr[31];
            tx_sr  <= {tx_sr[30:0], 1'b0};
            if (bit_cnt == 6'd0) begin
              state   <= TA;
              bit_cnt <= 6'd1;
              mdio_t  <= ~is_wr;
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
        end
        TA: begin
          if (fall_stb) begin
            mdio_o <= tx_sr[31];
            tx_sr  <= {tx_sr[30:0], 1'b0};
            if (bit_cnt == 6'd0) begin
              state   <= DATA;
              bit_cnt <= 6'd15;
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
        end
        DATA: begin
          if (fall_stb) begin
            if (bit_cnt == 6'd0) begin
              state     <= DONE;
              mdio_o    <= 1'b1;
              mdio_t    <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= is_wr ? 16'h0 : rx_sr;
              rsp_err   <= ~is_wr & ta_err;
            end else begin
              mdio_o  <= tx_sr[31];
              tx_sr   <= {tx_sr[30:0], 1'b0};
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mdio_master.sv
// Bench for eth_mdio_master: instance a (CLK_DIV=2, 32-bit preamble) and
// instance b (CLK_DIV=3, no preamble), each with a simple PHY model.
module tb_eth_mdio_master;
  import eth_mdio_pkg::*;

  // ---------------- clock / reset ----------------
  logic msoc_clk = 1'b0;
  logic rstn     = 1'b0;
  int   cyc      = 0;
  always #5 msoc_clk = ~msoc_clk;
  always @(posedge msoc_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // scoreboard: {err, rdata} per accepted request, plus its accept cycle
  logic [16:0] exp_q[$];
  int          acc_q[$];

  // ---------------- DUT a ----------------
  logic        a_req_valid = 1'b0, a_req_write = 1'b0;
  logic [4:0]  a_req_phyad = '0, a_req_regad = '0;
  logic [15:0] a_req_wdata = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy, a_mdc, a_mdio_o, a_mdio_t;
  logic [15:0] a_rsp_rdata;
  logic        a_mdio_i;
  mdio_state_t a_dbg_state;

  eth_mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut_a (
    .msoc_clk(msoc_clk), .rstn(rstn),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_phyad(a_req_phyad), .req_regad(a_req_regad), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .busy(a_busy), .mdc(a_mdc), .mdio_i(a_mdio_i), .mdio_o(a_mdio_o),
    .mdio_t(a_mdio_t), .dbg_state(a_dbg_state)
  );

  // ---------------- DUT b ----------------
  logic        b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [4:0]  b_req_phyad = '0, b_req_regad = '0;
  logic [15:0] b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy, b_mdc, b_mdio_o, b_mdio_t;
  logic [15:0] b_rsp_rdata;
  logic        b_mdio_i;
  mdio_state_t b_dbg_state;

  eth_mdio_master #(.CLK_DIV(3), .PREAMBLE_LEN(0)) dut_b (
    .msoc_clk(msoc_clk), .rstn(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_phyad(b_req_phyad), .req_regad(b_req_regad), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .busy(b_busy), .mdc(b_mdc), .mdio_i(b_mdio_i), .mdio_o(b_mdio_o),
    .mdio_t(b_mdio_t), .dbg_state(b_dbg_state)
  );

  // ---------------- PHY models / pad monitors ----------------
  // PHY value for frame bit j: TA bit 1 released (pull-up), TA bit 2 = 0,
  // then data MSB first. With no PHY the line idles at 1.
  function automatic logic phy_val(input int p, input int j, input logic drive,
                                   input logic [15:0] d);
    if (!drive) return 1'b1;
    if (j == p + 15) return 1'b0;
    if (j >= p + 16 && j < p + 32) return d[15 - (j - p - 16)];
    return 1'b1;
  endfunction

  logic        a_restart = 1'b0, a_phy_drive = 1'b0;
  logic [15:0] a_phy_data = '0;
  int          a_bit = 0;
  logic        a_obs_o[$], a_obs_t[$];
  // Record pad state at each rising mdc; present the next bit after the rise.
  always @(posedge a_mdc or posedge a_restart) begin
    if (a_restart) begin
      a_bit = 0; a_mdio_i = 1'b1; a_obs_o.delete(); a_obs_t.delete();
    end else begin
      a_obs_o.push_back(a_mdio_o); a_obs_t.push_back(a_mdio_t);
      a_bit = a_bit + 1;
      a_mdio_i = phy_val(32, a_bit, a_phy_drive, a_phy_data);
    end
  end

  logic        b_restart = 1'b0, b_phy_drive = 1'b0;
  logic [15:0] b_phy_data = '0;
  int          b_bit = 0;
  logic        b_obs_o[$], b_obs_t[$];
  // Same PHY model for the no-preamble instance.
  always @(posedge b_mdc or posedge b_restart) begin
    if (b_restart) begin
      b_bit = 0; b_mdio_i = 1'b1; b_obs_o.delete(); b_obs_t.delete();
    end else begin
      b_obs_o.push_back(b_mdio_o); b_obs_t.push_back(b_mdio_t);
      b_bit = b_bit + 1;
      b_mdio_i = phy_val(0, b_bit, b_phy_drive, b_phy_data);
    end
  end

  // Number of frame bits whose sampled o/t differ from the expected frame.
  function automatic int frame_errs(input int p, input logic wr, input logic [4:0] ph,
                                    input logic [4:0] rg, input logic [15:0] wd,
                                    input logic oq[$], input logic tq[$]);
    logic [31:0] body;
    logic        eo, et;
    int          n;
    n = 0;
    body = {2'b01, (wr ? 2'b01 : 2'b10), ph, rg, (wr ? 2'b10 : 2'b00), (wr ? wd : 16'h0)};
    if (oq.size() != p + 32 || tq.size() != p + 32) return 1000;
    for (int j = 0; j < p + 32; j++) begin
      eo = (j < p) ? 1'b1 : body[31 - (j - p)];
      et = (!wr && j >= p + 14) ? 1'b1 : 1'b0;
      if (tq[j] !== et) n++;
      if (et == 1'b0 && oq[j] !== eo) n++;
    end
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic issue_a(input logic wr, input logic [4:0] ph, input logic [4:0] rg,
                         input logic [15:0] wd, output int acc);
    @(negedge msoc_clk);
    a_req_valid = 1'b1; a_req_write = wr; a_req_phyad = ph; a_req_regad = rg; a_req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 3000 && acc < 0; i++) begin
      if (a_req_ready) acc = cyc;
      else @(negedge msoc_clk);
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL accept_a: got no req_ready want req_ready within 3000 cycles");
    end
    a_restart = 1'b1; #1 a_restart = 1'b0;
  endtask

  task automatic issue_b(input logic wr, input logic [4:0] ph, input logic [4:0] rg,
                         input logic [15:0] wd, output int acc);
    @(negedge msoc_clk);
    b_req_valid = 1'b1; b_req_write = wr; b_req_phyad = ph; b_req_regad = rg; b_req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 3000 && acc < 0; i++) begin
      if (b_req_ready) acc = cyc;
      else @(negedge msoc_clk);
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL accept_b: got no req_ready want req_ready within 3000 cycles");
    end
    b_restart = 1'b1; #1 b_restart = 1'b0;
  endtask

  // Waits for rsp_valid; also counts cycles where req_ready was seen high.
  task automatic wait_rsp_a(output logic got, output int rc, output int rdy_hi);
    got = 1'b0; rc = -1; rdy_hi = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge msoc_clk);
      if (a_rsp_valid) begin got = 1'b1; rc = cyc; end
      if (a_req_ready) rdy_hi++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rsp_timeout_a: got no rsp_valid want rsp_valid within 3000 cycles");
    end
  endtask

  task automatic wait_rsp_b(output logic got, output int rc);
    got = 1'b0; rc = -1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge msoc_clk);
      if (b_rsp_valid) begin got = 1'b1; rc = cyc; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rsp_timeout_b: got no rsp_valid want rsp_valid within 3000 cycles");
    end
  endtask

  // Pops the scoreboard and checks response data, error and latency for dut a.
  task automatic check_rsp_a(input string name, input int rc, input int lat);
    logic [16:0] e;
    int          ea;
    e = exp_q.pop_front(); ea = acc_q.pop_front();
    total++;
    if ({a_rsp_err, a_rsp_rdata} !== e) begin
      bad++;
      $display("FAIL %s_data: got err=%b rdata=%h want err=%b rdata=%h", name, a_rsp_err,
               a_rsp_rdata, e[16], e[15:0]);
    end
    total++;
    if (rc - ea !== lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, rc - ea, lat);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    a_restart = 1'b1; b_restart = 1'b1; #1 a_restart = 1'b0; b_restart = 1'b0;
    repeat (3) @(negedge msoc_clk);
    total++;
    if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy, a_mdc, a_mdio_o, a_mdio_t}
        !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_a: got rdy=%b v=%b d=%h e=%b busy=%b mdc=%b o=%b t=%b want 1 0 0000 0 0 0 1 1",
               a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy, a_mdc, a_mdio_o, a_mdio_t);
    end
    total++;
    if ({b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_busy, b_mdc, b_mdio_o, b_mdio_t}
        !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_b: got rdy=%b v=%b d=%h e=%b busy=%b mdc=%b o=%b t=%b want 1 0 0000 0 0 0 1 1",
               b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_busy, b_mdc, b_mdio_o, b_mdio_t);
    end
    total++;
    if (a_dbg_state !== IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", a_dbg_state, IDLE);
    end
    @(negedge msoc_clk); rstn = 1'b1;
    repeat (2) @(negedge msoc_clk);
  endtask

  task automatic test_write();
    int acc, rc, rh, fe;
    logic got;
    a_phy_drive = 1'b0;
    issue_a(1'b1, 5'd1, 5'd0, 16'h8000, acc);
    exp_q.push_back({1'b0, 16'h0000}); acc_q.push_back(acc);
    @(negedge msoc_clk); a_req_valid = 1'b0;
    wait_rsp_a(got, rc, rh);
    if (got) begin
      check_rsp_a("write", rc, 257);
      total++;
      if ({a_mdc, a_mdio_t, a_mdio_o, a_busy, a_req_ready} !== 5'b01110) begin
        bad++;
        $display("FAIL write_done_pads: got mdc=%b t=%b o=%b busy=%b rdy=%b want 0 1 1 1 0",
                 a_mdc, a_mdio_t, a_mdio_o, a_busy, a_req_ready);
      end
      fe = frame_errs(32, 1'b1, 5'd1, 5'd0, 16'h8000, a_obs_o, a_obs_t);
      total++;
      if (fe !== 0) begin bad++; $display("FAIL write_frame: got %0d bad bits want 0", fe); end
    end
  endtask

  task automatic test_read(input string name, input logic drive, input logic [4:0] ph,
                           input logic [4:0] rg, input logic [15:0] d, input logic [16:0] e);
    int acc, rc, rh, fe;
    logic got;
    a_phy_drive = drive; a_phy_data = d;
    issue_a(1'b0, ph, rg, 16'hDEAD, acc);
    exp_q.push_back(e); acc_q.push_back(acc);
    @(negedge msoc_clk); a_req_valid = 1'b0;
    wait_rsp_a(got, rc, rh);
    if (got) begin
      check_rsp_a(name, rc, 257);
      fe = frame_errs(32, 1'b0, ph, rg, 16'h0, a_obs_o, a_obs_t);
      total++;
      if (fe !== 0) begin bad++; $display("FAIL %s_frame: got %0d bad bits want 0", name, fe); end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, rc, rh, fe;
    logic got;
    a_phy_drive = 1'b1; a_phy_data = 16'hBEEF;
    issue_a(1'b1, 5'd3, 5'd4, 16'h1234, acc1);
    exp_q.push_back({1'b0, 16'h0000}); acc_q.push_back(acc1);
    // valid stays high; switch fields to the next (read) request while busy
    @(negedge msoc_clk);
    a_req_write = 1'b0; a_req_phyad = 5'd5; a_req_regad = 5'd6; a_req_wdata = 16'hFFFF;
    wait_rsp_a(got, rc, rh);
    total++;
    if (rh !== 0) begin bad++; $display("FAIL b2b_ready_busy: got %0d ready cycles want 0", rh); end
    if (got) begin
      check_rsp_a("b2b_first", rc, 257);
      fe = frame_errs(32, 1'b1, 5'd3, 5'd4, 16'h1234, a_obs_o, a_obs_t);
      total++;
      if (fe !== 0) begin bad++; $display("FAIL b2b_first_frame: got %0d bad bits want 0", fe); end
      issue_a(1'b0, 5'd5, 5'd6, 16'hFFFF, acc2);
      total++;
      if (acc2 !== rc + 1) begin
        bad++; $display("FAIL b2b_accept_gap: got %0d want %0d", acc2 - rc, 1);
      end
      exp_q.push_back({1'b0, 16'hBEEF}); acc_q.push_back(acc2);
      @(negedge msoc_clk); a_req_valid = 1'b0;
      wait_rsp_a(got, rc, rh);
      if (got) check_rsp_a("b2b_second", rc, 257);
    end else begin
      a_req_valid = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    int acc, nrsp;
    a_phy_drive = 1'b0;
    issue_a(1'b1, 5'd2, 5'd3, 16'h5A5A, acc);
    @(negedge msoc_clk); a_req_valid = 1'b0;
    // bit 48 (first DATA bit) starts 192 cycles after accept; go to roughly bit 57
    while (cyc < acc + 230) @(negedge msoc_clk);
    total++;
    if (a_busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %b want 1", a_busy); end
    rstn = 1'b0;
    #1;
    total++;
    if ({a_mdc, a_mdio_t, a_busy, a_req_ready, a_rsp_valid, a_mdio_o} !== 6'b010101) begin
      bad++;
      $display("FAIL abort_immediate: got mdc=%b t=%b busy=%b rdy=%b v=%b o=%b want 0 1 0 1 0 1",
               a_mdc, a_mdio_t, a_busy, a_req_ready, a_rsp_valid, a_mdio_o);
    end
    repeat (3) @(negedge msoc_clk);
    rstn = 1'b1;
    nrsp = 0;
    repeat (400) begin
      @(negedge msoc_clk);
      if (a_rsp_valid) nrsp++;
    end
    total++;
    if (nrsp !== 0) begin bad++; $display("FAIL abort_no_rsp: got %0d responses want 0", nrsp); end
    total++;
    if (a_req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", a_req_ready); end
  endtask

  task automatic test_no_preamble();
    int acc, rc, fe;
    logic got;
    logic [16:0] e;
    int ea;
    b_phy_drive = 1'b1; b_phy_data = 16'hA5C3;
    issue_b(1'b0, 5'd7, 5'd9, 16'h0, acc);
    exp_q.push_back({1'b0, 16'hA5C3}); acc_q.push_back(acc);
    @(negedge msoc_clk); b_req_valid = 1'b0;
    wait_rsp_b(got, rc);
    if (got) begin
      e = exp_q.pop_front(); ea = acc_q.pop_front();
      total++;
      if ({b_rsp_err, b_rsp_rdata} !== e) begin
        bad++;
        $display("FAIL nopre_data: got err=%b rdata=%h want err=%b rdata=%h", b_rsp_err,
                 b_rsp_rdata, e[16], e[15:0]);
      end
      total++;
      if (rc - ea !== 193) begin bad++; $display("FAIL nopre_latency: got %0d want 193", rc - ea); end
      total++;
      if (b_obs_o.size() == 0 || b_obs_o[0] !== 1'b0) begin
        bad++; $display("FAIL nopre_first_bit: got size=%0d want first bit 0", b_obs_o.size());
      end
      fe = frame_errs(0, 1'b0, 5'd7, 5'd9, 16'h0, b_obs_o, b_obs_t);
      total++;
      if (fe !== 0) begin bad++; $display("FAIL nopre_frame: got %0d bad bits want 0", fe); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write();
    test_read("read_phy", 1'b1, 5'd1, 5'd2, 16'h0022, {1'b0, 16'h0022});
    test_read("read_nophy", 1'b0, 5'h1f, 5'h1f, 16'h0000, {1'b1, 16'hFFFF});
    test_back_to_back();
    test_reset_abort();
    test_no_preamble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test want end before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
